systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_seq_ctrl.sv | 119 +++++++++++
 tb/tb_systolic_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears the array,
// streams skewed operands for k_len + 2N - 2 cycles, then hands out result rows.
module systolic_seq_ctrl #(
  parameter  int N  = 16,
  parameter  int KW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          arr_rst_n,
  output logic [KW:0]   feed_t,
  output logic [N-1:0]  lane_vld,
  output logic          res_valid,
  output logic [RW-1:0] res_row,
  input  logic          res_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [KW:0]     r_t;
  logic [RW-1:0]   r_row;
  logic            r_err;

  logic            w_in_feed;
  logic [KW+1:0]   w_t_wide;
  logic [KW+1:0]   w_t_last;
  logic [N-1:0]    w_lane_vld;

  // The last feed index is k_len + 2N - 3; the comparison runs one bit wider
  // than feed_t so that it cannot wrap even for the largest k_len.
  assign w_in_feed = (r_state == S_FEED);
  assign w_t_wide  = {1'b0, r_t};
  assign w_t_last  = {2'b00, r_k} + (KW+2)'(2*N - 3);

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // reads the pre-edge values of r_t, r_row and r_k regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_t     <= '0;
      r_row   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              r_k     <= k_len;
              r_err   <= 1'b0;
              r_state <= S_CLEAR;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          r_t     <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (w_t_wide == w_t_last) begin
            r_t     <= '0;
            r_row   <= '0;
            r_state <= S_OUT;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            if (r_row == RW'(N - 1)) begin
              r_row   <= '0;
              r_state <= S_DONE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane i sees its k_len operands during t = i .. i + k_len - 1.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_lane_vld[gi] = w_in_feed
                         && (w_t_wide >= (KW+2)'(gi))
                         && ((w_t_wide - (KW+2)'(gi)) < {2'b00, r_k});
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;
  assign arr_rst_n = !rst && (r_state != S_CLEAR);
  assign feed_t    = w_in_feed ? r_t : '0;
  assign lane_vld  = w_lane_vld;
  assign res_valid = (r_state == S_OUT);
  assign res_row   = r_row;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=16, KW=8): walks each pass cycle by
// cycle against a small phase model and checks every output.
module tb_systolic_seq_ctrl;

  localparam int N  = 16;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          arr_rst_n;
  logic [KW:0]   feed_t;
  logic [N-1:0]  lane_vld;
  logic          res_valid;
  logic [3:0]    res_row;
  logic          res_ready;

  int n_checks = 0;
  int n_errors = 0;

  systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .arr_rst_n (arr_rst_n),
    .feed_t    (feed_t),
    .lane_vld  (lane_vld),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_vld(input int t, input int k);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (t >= i) && (t - i < k);
    return v;
  endfunction

  // One accepted pass. c counts cycles after the start-sampling edge; the done
  // cycle is expected at c = 1 (clear) + k+2N-2 (feed) + accepted-row cycles + 1.
  // rmode 0 keeps res_ready high; rmode 1 drives the pattern 1,0,0,1,0,0,...
  task automatic run_pass(input int k, input int rmode, input bit inject);
    int c, acc, oidx, t;
    bit fin, r;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    c = 1; acc = 0; oidx = 0; fin = 1'b0;
    while (!fin) begin
      if (c == 1) begin
        check("clear_arr_rst_n", 32'(arr_rst_n), 32'd0);
        check("clear_busy",      32'(busy),      32'd1);
        check("clear_lane_vld",  32'(lane_vld),  32'd0);
        check("clear_feed_t",    32'(feed_t),    32'd0);
        start = 1'b0;
        k_len = 8'hAA;
      end else if (c <= k + 2*N - 1) begin
        t = c - 2;
        check("feed_t",         32'(feed_t),    32'(t));
        check("feed_lane_vld",  32'(lane_vld),  32'(exp_vld(t, k)));
        check("feed_arr_rst_n", 32'(arr_rst_n), 32'd1);
        check("feed_res_valid", 32'(res_valid), 32'd0);
        check("feed_done",      32'(done),      32'd0);
        start = inject && (t == 5);
      end else if (acc < N) begin
        check("out_res_valid", 32'(res_valid), 32'd1);
        check("out_res_row",   32'(res_row),   32'(acc));
        check("out_lane_vld",  32'(lane_vld),  32'd0);
        check("out_feed_t",    32'(feed_t),    32'd0);
        check("out_done",      32'(done),      32'd0);
        start = inject && (oidx == 0);
        r = (rmode == 0) ? 1'b1 : ((oidx % 3) == 0);
        res_ready = r;
        if (r) acc++;
        oidx++;
      end else begin
        check("done_pulse", 32'(done),      32'd1);
        check("done_err",   32'(err),       32'd0);
        check("done_busy",  32'(busy),      32'd1);
        check("done_valid", 32'(res_valid), 32'd0);
        res_ready = 1'b1;
        start = 1'b0;
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        c++;
        if (c > 2000) begin
          check("pass_timeout", 32'(c), 32'd2000);
          fin = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("after_busy", 32'(busy), 32'd0);
    check("after_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_lane_vld",  32'(lane_vld),  32'd0);
    check("rst_feed_t",    32'(feed_t),    32'd0);
    check("rst_arr_rst_n", 32'(arr_rst_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_arr_rst_n", 32'(arr_rst_n), 32'd1);

    // k_len=1: one-hot diagonal wavefront, done 49 cycles after start.
    run_pass(1, 0, 1'b0);
    // k_len=16: full lanes at t=15, empty at t=31, done at cycle 64.
    run_pass(16, 0, 1'b0);

    // k_len=0 is rejected: done+err one cycle after start, array untouched.
    @(negedge clk);
    start = 1'b1; k_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("rej_done",      32'(done),      32'd1);
    check("rej_err",       32'(err),       32'd1);
    check("rej_busy",      32'(busy),      32'd1);
    check("rej_arr_rst_n", 32'(arr_rst_n), 32'd1);
    @(negedge clk);
    check("rej_idle_busy", 32'(busy),      32'd0);
    check("rej_idle_done", 32'(done),      32'd0);
    check("rej_idle_err",  32'(err),       32'd0);
    check("rej_idle_arr",  32'(arr_rst_n), 32'd1);

    // k_len=4 with back-pressure: rows held while ready is low.
    run_pass(4, 1, 1'b0);

    // Stray starts in FEED and OUT must not spawn a second pass.
    run_pass(3, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_second_pass_busy", 32'(busy), 32'd0);
      check("no_second_pass_done", 32'(done), 32'd0);
    end

    // Reset at FEED t=10, then a clean k_len=2 pass completing at cycle 50.
    @(negedge clk);
    start = 1'b1; k_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_rst_feed_t", 32'(feed_t), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_lane_vld",  32'(lane_vld),  32'd0);
    check("mid_rst_feed_t",    32'(feed_t),    32'd0);
    check("mid_rst_arr_rst_n", 32'(arr_rst_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy),      32'd0);
    check("post_rst_arr",  32'(arr_rst_n), 32'd1);
    run_pass(2, 0, 1'b0);

    // k_len=255: lane 15 live for t=15..269, feed of 285 cycles, no wrap.
    run_pass(255, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
